bht_predictor: RTL and testbench
================================

// Module: bht_predictor
// PURPOSE
//  Branch history table of 2-bit saturating counters: the read side of the 2-bit state the pipeline writes.
//  IF stage looks up a prediction by PC; EX stage writes back the resolved branch outcome.
//  Registered 1-cycle read; same-cycle read/write to the same entry is bypassed (write-first).
//  Also keeps a saturating mispredict counter for performance debug.
// PARAMETERS
//  IDX_W      6      table index width; ENTRIES = 2**IDX_W (64)
//  PC_W       32     program counter width
//  INIT_ST    2'b01  entry value after reset/clear (weakly not-taken)
//  CNT_W      16     mispredict counter width
// PORTS
//  clk         in   1      clock, all state on posedge
//  reset       in   1      asynchronous, active-low; clears all state
//  clr         in   1      synchronous table + counter clear
//  rd_en       in   1      IF lookup valid
//  rd_pc       in   PC_W   IF PC to predict
//  pred_valid  out  1      prediction valid (rd_en delayed 1 cycle)
//  pred_taken  out  1      predicted direction = pred_state[1]
//  pred_state  out  2      counter value read
//  upd_en      in   1      EX resolved-branch update valid
//  upd_pc      in   PC_W   PC of resolved branch
//  upd_taken   in   1      actual outcome
//  upd_pred    in   1      direction that was predicted for it
//  mispred_cnt out  CNT_W  saturating count of upd_en with upd_taken != upd_pred
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2] (word-aligned instructions); no tags, aliasing is allowed.
//  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - Update: taken -> state+1, saturating at 11; not-taken -> state-1, saturating at 00.
//  - Read latency: 1 cycle. pred_* are registered on every clk edge.
//    pred_valid <= rd_en.
//    pred_state <= table[rd_idx], or the value being written this cycle when upd_en && upd_idx==rd_idx.
//    With rd_en=0, pred_state/pred_taken hold their previous values.
//  - Mispredict: mispred_cnt += 1 when upd_en && upd_taken!=upd_pred; saturates at all-ones, never wraps.
//  - Priority: reset > clr > upd_en.
//    clr=1: next edge sets every entry to INIT_ST, pred_valid=0, pred_state=INIT_ST, mispred_cnt=0.
//    clr=1: any concurrent upd_en is dropped and any rd_en returns no valid prediction.
//  - Reset (asserting reset low, including mid-operation) immediately, asynchronously forces:
//    all entries=INIT_ST, pred_valid=0, pred_taken=0, pred_state=INIT_ST, mispred_cnt=0.
//    First rd_en after deassertion yields INIT_ST.
//  - Different-index read and write in the same cycle are independent.
//  - Only one update per cycle.
// STRUCTURE
//  - Shared package: bht_state_t (2-bit enum SNT/WNT/WT/ST), default INIT_ST, bht_idx() index function.
//  - Sub-module sat_cnt2: combinational next-state from (state, taken).
//    Instantiated once for the write path; its output also feeds the bypass mux.
//  - Table is a flop array (async reset required), not inferred RAM.
// TESTING
//  1 reset low mid-stream, then release; rd_pc=0x100 -> next cycle pred_valid=1, pred_state=01, pred_taken=0.
//  2 upd_en taken x3 at pc 0x100 -> states 10,11,11 (saturates); read of 0x100 -> pred_taken=1.
//  3 not-taken x4 from 11 -> 10,01,00,00; read returns 00.
//  4 same cycle: rd_pc=upd_pc=0x40, state 01, upd_taken=1 -> pred_state=10 (bypass);
//    rd 0x44 same cycle -> unaffected 01.
//  5 aliasing: 0x100 and 0x200 (IDX_W=6) share index 0; updating one changes the prediction of the other.
//  6 mispred: 3 updates with taken!=pred and 2 with taken==pred -> mispred_cnt=3.
//    Preload near 0xFFFF -> holds 0xFFFF.
//    clr=1 with upd_en=1 -> counter 0, table all 01, update dropped.

Source files
------------

// File: rtl/bht_predictor_pkg.sv
// Shared definitions for the branch history table.
//   bht_state_t : 2-bit saturating direction counter encoding
//   BHT_INIT_ST : entry value after reset/clear (weakly not-taken)
//   bht_idx()   : PC to table index (word-aligned, untagged)
package bht_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } bht_state_t;

  localparam int         BHT_IDX_W   = 6;
  localparam int         BHT_PC_W    = 32;
  localparam int         BHT_CNT_W   = 16;
  localparam logic [1:0] BHT_INIT_ST = 2'b01;

  // Drops the two byte-offset bits and keeps idx_w bits above them.
  // The result is full PC width; callers truncate to their index width.
  function automatic logic [BHT_PC_W-1:0] bht_idx(input logic [BHT_PC_W-1:0] pc,
                                                  input int unsigned        idx_w);
    logic [BHT_PC_W-1:0] mask;
    mask = (BHT_PC_W'(1) << idx_w) - BHT_PC_W'(1);
    return (pc >> 2) & mask;
  endfunction

endpackage

// File: rtl/bht_predictor_sat_cnt2.sv
// Combinational next-state for a 2-bit saturating direction counter.
//   state : current counter value
//   taken : resolved branch outcome
//   next  : state+1 (sat at ST) if taken, state-1 (sat at SNT) otherwise
module sat_cnt2
  import bht_predictor_pkg::*;
(
  input  bht_state_t state,
  input  logic       taken,
  output bht_state_t next
);

  always_comb begin
    next = state;
    if (taken) begin
      if (state != ST) next = bht_state_t'(state + 2'd1);
    end else begin
      if (state != SNT) next = bht_state_t'(state - 2'd1);
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table of 2-bit saturating counters.
//   clk, reset (async, active-low), clr (sync clear of table and counter)
//   rd_en/rd_pc          : IF lookup; result appears on pred_* one cycle later
//   pred_valid/taken/state : registered prediction; state holds when rd_en=0
//   upd_en/upd_pc/upd_taken/upd_pred : EX resolved-branch write-back
//   mispred_cnt          : saturating count of updates where outcome != prediction
// A read and write to the same entry in one cycle returns the written value.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int         IDX_W   = BHT_IDX_W,
  parameter int         PC_W    = BHT_PC_W,
  parameter logic [1:0] INIT_ST = BHT_INIT_ST,
  parameter int         CNT_W   = BHT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             rd_en,
  input  logic [PC_W-1:0]  rd_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [1:0]       pred_state,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_W;

  bht_state_t             tbl [ENTRIES];
  bht_state_t             pred_st;
  bht_state_t             upd_cur;
  bht_state_t             upd_next;
  logic       [IDX_W-1:0] rd_idx;
  logic       [IDX_W-1:0] upd_idx;
  logic                   bypass;
  logic                   mispred;

  assign rd_idx  = IDX_W'(bht_idx(BHT_PC_W'(rd_pc), IDX_W));
  assign upd_idx = IDX_W'(bht_idx(BHT_PC_W'(upd_pc), IDX_W));
  assign upd_cur = tbl[upd_idx];
  assign bypass  = upd_en && (upd_idx == rd_idx);
  assign mispred = upd_en && (upd_taken != upd_pred);

  // Single next-state generator: feeds both the table write and the read bypass.
  sat_cnt2 u_sat_cnt2 (
    .state (upd_cur),
    .taken (upd_taken),
    .next  (upd_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= bht_state_t'(INIT_ST);
    end else if (clr) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= bht_state_t'(INIT_ST);
    end else if (upd_en) begin
      tbl[upd_idx] <= upd_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pred_valid <= 1'b0;
      pred_st    <= bht_state_t'(INIT_ST);
    end else if (clr) begin
      pred_valid <= 1'b0;
      pred_st    <= bht_state_t'(INIT_ST);
    end else begin
      pred_valid <= rd_en;
      if (rd_en) pred_st <= bypass ? upd_next : tbl[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mispred_cnt <= '0;
    end else if (clr) begin
      mispred_cnt <= '0;
    end else if (mispred && (mispred_cnt != {CNT_W{1'b1}})) begin
      mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

  assign pred_state = pred_st;
  assign pred_taken = pred_st[1];

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor: directed scenarios plus random traffic
// compared against an array-based reference model of the predictor table.
module tb_bht_predictor;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        rd_en;
  logic [31:0] rd_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [1:0]  pred_state;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic [15:0] mispred_cnt;

  int n_vec;
  int n_err;

  // Reference model
  int mdl [64];
  int exp_valid;
  int exp_state;
  int exp_cnt;

  bht_predictor dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .rd_en       (rd_en),
    .rd_pc       (rd_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_state  (pred_state),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_pred    (upd_pred),
    .mispred_cnt (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    exp_valid = 0;
    exp_state = 1;
    exp_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"},   32'(pred_valid),  32'(exp_valid));
    chk({tag, ".state"},   32'(pred_state),  32'(exp_state));
    chk({tag, ".taken"},   32'(pred_taken),  32'(exp_state >= 2));
    chk({tag, ".mispred"}, 32'(mispred_cnt), 32'(exp_cnt));
  endtask

  // Drive one cycle of inputs, advance the model, clock, and compare.
  task automatic apply(input string tag, input logic re, input logic [31:0] rp,
                       input logic ue, input logic [31:0] up, input logic ut,
                       input logic upr, input logic cl);
    int ri, ui, nu;
    rd_en = re; rd_pc = rp; upd_en = ue; upd_pc = up;
    upd_taken = ut; upd_pred = upr; clr = cl;
    ri = int'((rp / 4) % 64);
    ui = int'((up / 4) % 64);
    if (cl) begin
      model_clear();
    end else begin
      nu = ut ? ((mdl[ui] == 3) ? 3 : mdl[ui] + 1) : ((mdl[ui] == 0) ? 0 : mdl[ui] - 1);
      exp_valid = int'(re);
      if (re) exp_state = (ue && ui == ri) ? nu : mdl[ri];
      if (ue) mdl[ui] = nu;
      if (ue && ut != upr && exp_cnt < 65535) exp_cnt++;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    rd_en = 0; upd_en = 0; clr = 0;
  endtask

  int pcs [8];

  initial begin
    n_vec = 0;
    n_err = 0;
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h40;  pcs[3] = 32'h44;
    pcs[4] = 32'h104; pcs[5] = 32'h1fc; pcs[6] = 32'h300; pcs[7] = 32'h0;
    reset = 1'b0; clr = 0; rd_en = 0; rd_pc = 0; upd_en = 0; upd_pc = 0;
    upd_taken = 0; upd_pred = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por");
    reset = 1'b1;

    // Some traffic, then an asynchronous reset mid-stream.
    apply("pre", 1, 32'h100, 1, 32'h100, 1, 0, 0);
    apply("pre", 1, 32'h100, 1, 32'h100, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_outputs("async_rst");
    @(posedge clk);
    #1 reset = 1'b1;
    apply("rst_rd", 1, 32'h100, 0, 0, 0, 0, 0);
    chk("rst_rd.state_lit", 32'(pred_state), 32'h1);

    // Taken x3 saturates at 11, observed via bypass.
    for (int i = 0; i < 3; i++) apply("sat_up", 1, 32'h100, 1, 32'h100, 1, 1, 0);
    chk("sat_up.lit", 32'(pred_state), 32'h3);
    apply("sat_rd", 1, 32'h100, 0, 0, 0, 0, 0);
    // Not-taken x4 from 11 bottoms out at 00.
    for (int i = 0; i < 4; i++) apply("sat_dn", 1, 32'h100, 1, 32'h100, 0, 0, 0);
    apply("sat_dn_rd", 1, 32'h100, 0, 0, 0, 0, 0);
    chk("sat_dn.lit", 32'(pred_state), 32'h0);

    // Bypass on same index; different index unaffected.
    apply("byp", 1, 32'h40, 1, 32'h40, 1, 1, 0);
    chk("byp.lit", 32'(pred_state), 32'h2);
    apply("nobyp", 1, 32'h44, 1, 32'h40, 1, 1, 0);
    chk("nobyp.lit", 32'(pred_state), 32'h1);

    // rd_en=0 holds the last prediction.
    apply("hold", 0, 32'h40, 0, 0, 0, 0, 0);

    // Aliasing: 0x200 shares index 0 with 0x100 (currently 00).
    apply("alias", 0, 0, 1, 32'h200, 1, 1, 0);
    apply("alias", 0, 0, 1, 32'h200, 1, 1, 0);
    apply("alias_rd", 1, 32'h100, 0, 0, 0, 0, 0);

    // Mispredict counting from zero after a clear.
    apply("clr0", 1, 32'h100, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) apply("mp_bad", 0, 0, 1, 32'h80, i[0], ~i[0], 0);
    for (int i = 0; i < 2; i++) apply("mp_ok", 0, 0, 1, 32'h80, 1, 1, 0);
    chk("mp.lit", 32'(mispred_cnt), 32'd3);

    // Clear wins over a concurrent update and read.
    apply("clr_upd", 1, 32'h80, 1, 32'h80, 1, 0, 1);
    chk("clr_upd.cnt", 32'(mispred_cnt), 32'd0);
    for (int i = 0; i < 64; i++) apply("clr_scan", 1, 32'(i * 4), 0, 0, 0, 0, 0);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      apply("rnd", 1'($urandom_range(0, 1)), 32'(pcs[$urandom_range(0, 7)]),
            1'($urandom_range(0, 1)), 32'(pcs[$urandom_range(0, 7)]),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end

    // Drive the mispredict counter into saturation.
    apply("sat_clr", 0, 0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 65540; n++) apply("cnt_sat", 0, 0, 1, 32'h8, 1, 0, 0);
    chk("cnt_sat.lit", 32'(mispred_cnt), 32'hffff);
    apply("cnt_hold", 0, 0, 1, 32'h8, 0, 1, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
